// File: rtl/contador_vagas_bcd_if.sv
// Signal bundle between the parking occupancy counter and its surroundings:
// sensor and enable inputs, and the display and status outputs.
interface contador_vagas_bcd_if;
    logic        sensor_entrada;
    logic        sensor_saida;
    logic        habilitar;
    logic [15:0] dados;
    logic        on_off_DEMUX;
    logic        lotado;
    logic        vazio;
    logic        erro_lotado;

    modport master (
        output sensor_entrada,
        output sensor_saida,
        output habilitar,
        input  dados,
        input  on_off_DEMUX,
        input  lotado,
        input  vazio,
        input  erro_lotado
    );

    modport slave (
        input  sensor_entrada,
        input  sensor_saida,
        input  habilitar,
        output dados,
        output on_off_DEMUX,
        output lotado,
        output vazio,
        output erro_lotado
    );
endinterface

// File: rtl/contador_vagas_bcd.sv
// Parking occupancy counter kept as four BCD digits, with leading-zero blanking
// and a display enable that blinks while the lot is full.
module contador_vagas_bcd #(
    parameter int unsigned CAPACIDADE   = 250,
    parameter int unsigned PISCA_CICLOS = 25000
) (
    input logic                 clk,
    input logic                 rst_n,
    contador_vagas_bcd_if.slave bus
);

    localparam int unsigned BW = (PISCA_CICLOS > 1) ? $clog2(PISCA_CICLOS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(PISCA_CICLOS - 1);
    localparam logic [15:0] CAP_BCD = {4'((CAPACIDADE / 1000) % 10),
                                       4'((CAPACIDADE / 100) % 10),
                                       4'((CAPACIDADE / 10) % 10),
                                       4'(CAPACIDADE % 10)};
    localparam logic [3:0] BLANK = 4'hA;

    typedef enum logic [1:0] {DESLIGADO, LIGADO, PISCA_ON, PISCA_OFF} estado_t;

    // Digit-wise BCD increment: 9 wraps to 0 and carries onward.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Digit-wise BCD decrement: 0 wraps to 9 and borrows onward.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Bit 0 = s1, bit 1 = s2, bit 2 = s3 (history).
    logic [2:0]    ent_sync_q, sai_sync_q;
    logic          ev_ent, ev_sai;
    logic [15:0]   count_q, count_d;
    logic [15:0]   dados_q, dados_d;
    logic          erro_q, erro_d;
    logic          cheio, vazio;
    estado_t       estado_q, estado_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          on_off_q, on_off_d;
    logic          blank3, blank2, blank1;

    assign ev_ent = ent_sync_q[1] & ~ent_sync_q[2];
    assign ev_sai = sai_sync_q[1] & ~sai_sync_q[2];
    assign cheio  = (count_q == CAP_BCD);
    assign vazio  = (count_q == 16'h0000);

    always_comb begin
        count_d = count_q;
        erro_d  = 1'b0;
        unique case ({ev_ent, ev_sai})
            2'b10: begin
                if (cheio) erro_d  = 1'b1;
                else       count_d = bcd_inc(count_q);
            end
            2'b01: begin
                if (!vazio) count_d = bcd_dec(count_q);
            end
            default: ;
        endcase
    end

    // A digit blanks only when it and everything above it are zero.
    always_comb begin
        blank3  = (count_q[15:12] == 4'd0);
        blank2  = blank3 & (count_q[11:8] == 4'd0);
        blank1  = blank2 & (count_q[7:4] == 4'd0);
        dados_d = count_q;
        if (blank3) dados_d[15:12] = BLANK;
        if (blank2) dados_d[11:8]  = BLANK;
        if (blank1) dados_d[7:4]   = BLANK;
    end

    always_comb begin
        estado_d = estado_q;
        blink_d  = blink_q;
        if (!bus.habilitar) begin
            estado_d = DESLIGADO;
            blink_d  = '0;
        end else if (!cheio) begin
            estado_d = LIGADO;
            blink_d  = '0;
        end else begin
            unique case (estado_q)
                DESLIGADO, LIGADO: begin
                    estado_d = PISCA_ON;
                    blink_d  = '0;
                end
                PISCA_ON: begin
                    if (blink_q == BLINK_LAST) begin
                        estado_d = PISCA_OFF;
                        blink_d  = '0;
                    end else begin
                        blink_d = blink_q + BW'(1);
                    end
                end
                PISCA_OFF: begin
                    if (blink_q == BLINK_LAST) begin
                        estado_d = PISCA_ON;
                        blink_d  = '0;
                    end else begin
                        blink_d = blink_q + BW'(1);
                    end
                end
                default: ;
            endcase
        end
        // Registered from the next state so a habilitar change shows after one edge.
        on_off_d = (estado_d == LIGADO) || (estado_d == PISCA_ON);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_sync_q <= '0;
            sai_sync_q <= '0;
            count_q    <= '0;
            dados_q    <= 16'hAAA0;
            erro_q     <= 1'b0;
            estado_q   <= DESLIGADO;
            blink_q    <= '0;
            on_off_q   <= 1'b0;
        end else begin
            ent_sync_q <= {ent_sync_q[1:0], bus.sensor_entrada};
            sai_sync_q <= {sai_sync_q[1:0], bus.sensor_saida};
            count_q    <= count_d;
            dados_q    <= dados_d;
            erro_q     <= erro_d;
            estado_q   <= estado_d;
            blink_q    <= blink_d;
            on_off_q   <= on_off_d;
        end
    end

    assign bus.dados        = dados_q;
    assign bus.on_off_DEMUX = on_off_q;
    assign bus.lotado       = cheio;
    assign bus.vazio        = vazio;
    assign bus.erro_lotado  = erro_q;

endmodule

// File: doc/contador_vagas_bcd.md
# contador_vagas_bcd

Occupancy counter for the parking access controller. It counts vehicles entering and leaving from two sensor inputs and holds the count as four BCD digits. It drives the 16-bit digit word and the display-enable line of the four-digit multiplexed display stage. Leading zeros are blanked with code 4'hA, and the display blinks while the lot is full.

## Interface
- CAPACIDADE, 250: maximum occupancy; legal range 1..9999.
- PISCA_CICLOS, 25000: clock cycles per blink half-period while full; minimum 1.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sensor_entrada  in  1  asynchronous level from the entry sensor; each rising edge is one vehicle in.
- sensor_saida  in  1  asynchronous level from the exit sensor; each rising edge is one vehicle out.
- habilitar  in  1  display master enable; has no effect on counting.
- dados  out  16  display word; [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands; 4'hA = blank digit.
- on_off_DEMUX  out  1  display enable for the multiplexed display.
- lotado  out  1  high while count == CAPACIDADE.
- vazio  out  1  high while count == 0.
- erro_lotado  out  1  one-cycle pulse when an entry is rejected because the lot is full.

## Operation
- Each sensor passes through a 2-FF synchronizer (s1, s2) and then a history FF (s3). An edge event is s2 & ~s3.
- The count is held as four BCD digit registers. Increment and decrement are done digit-wise in BCD:
  - increment: 9 rolls to 0 and carries into the next digit;
  - decrement: 0 rolls to 9 and borrows from the next digit.
  - No binary-to-BCD conversion is used.
- Event resolution in a given cycle:
  - entry only, count < CAPACIDADE: count + 1.
  - entry only, count == CAPACIDADE: count unchanged; erro_lotado = 1 for one cycle.
  - exit only, count > 0: count − 1.
  - exit only, count == 0: ignored silently.
  - entry and exit in the same cycle: count unchanged, no error pulse, even when full.
- Blanking, applied when dados is registered:
  - a digit is replaced by 4'hA if it and every more-significant digit are 0;
  - the units digit is never blanked.
- Display enable states: DESLIGADO, LIGADO, PISCA_ON, PISCA_OFF.
  - habilitar = 0 forces DESLIGADO from any state.
  - habilitar = 1 and not lotado gives LIGADO.
  - habilitar = 1 and lotado: entering from LIGADO or DESLIGADO goes to PISCA_ON with the blink counter cleared.
  - PISCA_ON and PISCA_OFF swap each time the blink counter reaches PISCA_CICLOS − 1; the counter then clears.
  - When lotado falls, the state returns to LIGADO.
- on_off_DEMUX = 1 in LIGADO and PISCA_ON only.
- lotado and vazio are decoded from the count registers.

## Timing
- Reset values:
  - count = 0, dados = 16'hAAA0;
  - on_off_DEMUX = 0 (state DESLIGADO), lotado = 0, vazio = 1, erro_lotado = 0;
  - synchronizers = 0, blink counter = 0.
- Sensor latency, with the sensor rising before edge k:
  - s1 = 1 after edge k;
  - the count updates at edge k+2;
  - lotado, vazio and erro_lotado change at edge k+2;
  - dados reflects the new count after edge k+3.
- Each sensor pulse must stay high for at least 2 cycles and low for at least 2 cycles. Shorter pulses may be missed; this is not an error.
- on_off_DEMUX is registered and follows the state register. A habilitar change appears after one edge.
- Blink: while full and enabled, on_off_DEMUX has period 2·PISCA_CICLOS cycles and starts high.
- A sensor held high counts exactly once.
- Reset asserted mid-operation clears all state immediately, with no clock. After release, a sensor already high is seen as a new rising edge: s3 reset to 0 gives one count.

## Test plan
- Reset, then no activity: dados = 16'hAAA0, vazio = 1, on_off_DEMUX = 0; one cycle after habilitar = 1, on_off_DEMUX = 1.
- 10 entry pulses (3 high / 3 low): dados passes 16'hAAA9 then 16'hAA10. At 99 followed by 1 entry, dados = 16'hA100. 1 exit from 100 gives 16'hAA99.
- CAPACIDADE = 3, 4 entries:
  - count stays 3, lotado = 1;
  - erro_lotado pulses once, at edge k+2 of the 4th pulse;
  - with PISCA_CICLOS = 4, on_off_DEMUX toggles every 4 cycles, starting high;
  - 1 exit gives a steady on_off_DEMUX = 1 and dados = 16'hAAA2.
- Exit pulse at count 0: dados stays 16'hAAA0, no erro_lotado.
- Entry and exit rising in the same cycle at count 5, and again at full: count unchanged, no erro_lotado.
- At count 7, a 1-cycle rst_n pulse mid-operation with sensor_entrada held high: dados = 16'hAAA0 immediately; after release, count becomes 1 exactly once.
